// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: bus payloads, FSM state enum, limits.
package dmem_ctrl_pkg;

  localparam int unsigned dmem_max_latency_gp = 15;
  localparam int unsigned dmem_cnt_width_gp   = 4;
  localparam int unsigned dmem_data_width_gp  = 32;
  localparam int unsigned dmem_lanes_gp       = 4;

  typedef enum logic [1:0] {
    DMEM_C_IDLE = 2'd0,
    DMEM_C_BUSY = 2'd1,
    DMEM_C_RESP = 2'd2
  } dmem_ctrl_state_e;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  // One-hot byte enable for a single lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Core <-> data-memory bus: request payload, byte address, response payload, misalign flag.
interface dmem_ctrl_if;
  import dmem_ctrl_pkg::*;

  mem_in_s     to_mem_i;
  logic [31:0] addr_i;
  mem_out_s    from_mem_o;
  logic        error_o;

  modport master (output to_mem_i, output addr_i, input from_mem_o, input error_o);
  modport slave  (input to_mem_i, input addr_i, output from_mem_o, output error_o);
endinterface

// File: rtl/dmem_ram.sv
// Single-port word array with per-byte write enables, synchronous write, asynchronous read.
module dmem_ram #(
  parameter int unsigned addr_width_p = 10
) (
  input  logic                    clk,
  input  logic [3:0]              byte_en,
  input  logic [addr_width_p-1:0] addr,
  input  logic [31:0]             write_data,
  output logic [31:0]             read_data
);

  localparam int unsigned depth_lp = 2 ** addr_width_p;

  logic [31:0] mem_r [depth_lp];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (byte_en[b]) mem_r[addr][8*b +: 8] <= write_data[8*b +: 8];
    end
  end

  assign read_data = mem_r[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one request at a time, responds after latency_p cycles.
// Optional misaligned word-access checking is enabled by defining DMEM_CTRL_MISALIGN_EXC_EN.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned addr_width_p = 10,
  parameter int unsigned latency_p    = 2
) (
  input logic        clk,
  input logic        reset,
  dmem_ctrl_if.slave mem_bus
);

  if (latency_p < 1 || latency_p > dmem_max_latency_gp) begin : g_bad_latency
    $error("dmem_ctrl: latency_p must be within 1..15");
  end

  localparam logic [1:0] st_idle_lp = 2'(DMEM_C_IDLE);
  localparam logic [1:0] st_busy_lp = 2'(DMEM_C_BUSY);
  localparam logic [1:0] st_resp_lp = 2'(DMEM_C_RESP);
  localparam logic [dmem_cnt_width_gp-1:0] cnt_load_lp = dmem_cnt_width_gp'(latency_p - 1);

  logic [1:0]                   state_r, state_n;
  logic [dmem_cnt_width_gp-1:0] cnt_r, cnt_n;
  logic [31:0]                  resp_data_r, resp_data_n;
  logic                         resp_err_r, resp_err_n;

  logic                    accept_c, misalign_c;
  logic [1:0]              lane_c;
  logic [addr_width_p-1:0] word_addr_c;
  logic [3:0]              byte_en_c;
  logic [31:0]             ram_wdata_c, ram_rdata_c, load_data_c;
  logic [7:0]              lane_byte_c;
  mem_out_s                out_c;
  logic                    unused_addr_c;

  assign lane_c        = mem_bus.addr_i[1:0];
  assign word_addr_c   = mem_bus.addr_i[addr_width_p+1:2];
  assign unused_addr_c = ^mem_bus.addr_i[31:addr_width_p+2];
  assign accept_c      = ~reset & (state_r == st_idle_lp) & mem_bus.to_mem_i.valid;

`ifdef DMEM_CTRL_MISALIGN_EXC_EN
  assign misalign_c = ~mem_bus.to_mem_i.byte_not_word & (lane_c != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  // Store path: commit at the acceptance edge, byte stores replicate the low byte to the chosen lane.
  always_comb begin
    byte_en_c   = 4'b0000;
    ram_wdata_c = mem_bus.to_mem_i.write_data;
    if (accept_c && mem_bus.to_mem_i.wen && !misalign_c) begin
      if (mem_bus.to_mem_i.byte_not_word) begin
        byte_en_c   = lane_mask(lane_c);
        ram_wdata_c = {4{mem_bus.to_mem_i.write_data[7:0]}};
      end else begin
        byte_en_c = 4'hF;
      end
    end
  end

  dmem_ram #(.addr_width_p(addr_width_p)) u_ram (
    .clk        (clk),
    .byte_en    (byte_en_c),
    .addr       (word_addr_c),
    .write_data (ram_wdata_c),
    .read_data  (ram_rdata_c)
  );

  // Load path: little-endian lane select, zero for stores and rejected accesses.
  always_comb begin
    lane_byte_c = ram_rdata_c[7:0];
    case (lane_c)
      2'd0: lane_byte_c = ram_rdata_c[7:0];
      2'd1: lane_byte_c = ram_rdata_c[15:8];
      2'd2: lane_byte_c = ram_rdata_c[23:16];
      2'd3: lane_byte_c = ram_rdata_c[31:24];
      default: lane_byte_c = ram_rdata_c[7:0];
    endcase
    load_data_c = mem_bus.to_mem_i.byte_not_word ? {24'h0, lane_byte_c} : ram_rdata_c;
    if (mem_bus.to_mem_i.wen || misalign_c) load_data_c = 32'h0;
  end

  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    resp_data_n = resp_data_r;
    resp_err_n  = resp_err_r;
    case (state_r)
      st_idle_lp: begin
        if (accept_c) begin
          resp_data_n = load_data_c;
          resp_err_n  = misalign_c;
          cnt_n       = cnt_load_lp;
          state_n     = (latency_p == 1) ? st_resp_lp : st_busy_lp;
        end
      end
      st_busy_lp: begin
        cnt_n = cnt_r - dmem_cnt_width_gp'(1);
        if (cnt_r <= dmem_cnt_width_gp'(1)) begin
          cnt_n   = '0;
          state_n = st_resp_lp;
        end
      end
      st_resp_lp: begin
        if (mem_bus.to_mem_i.yumi) state_n = st_idle_lp;
      end
      default: state_n = st_idle_lp;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= st_idle_lp;
      cnt_r       <= '0;
      resp_data_r <= '0;
      resp_err_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      resp_data_r <= resp_data_n;
      resp_err_r  <= resp_err_n;
    end
  end

  // Outputs are forced low while reset is held, since reset only takes effect at the edge.
  always_comb begin
    out_c.valid     = ~reset & (state_r == st_resp_lp);
    out_c.yumi      = accept_c;
    out_c.read_data = out_c.valid ? resp_data_r : 32'h0;
  end

  assign mem_bus.from_mem_o = out_c;
  assign mem_bus.error_o    = out_c.valid & resp_err_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: transaction-level reference model plus directed vectors.
`timescale 1ns/1ps
module tb_dmem_ctrl;

  localparam int unsigned aw_lp  = 10;
  localparam int          lat_lp = 2;
`ifdef DMEM_CTRL_MISALIGN_EXC_EN
  localparam bit mis_en_lp = 1'b1;
`else
  localparam bit mis_en_lp = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.addr_width_p(aw_lp), .latency_p(lat_lp)) dut (
    .clk     (clk),
    .reset   (reset),
    .mem_bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
  endfunction

  // Reference model: one outstanding request, response visible lat_lp edges after acceptance.
  logic [31:0] ref_mem [int];
  bit          m_pend  = 1'b0;
  int          m_edges = 0;
  logic [31:0] m_data  = 32'h0;
  bit          m_err   = 1'b0;

  always @(posedge clk) begin
    int          idx, sh;
    logic [31:0] word, wd;
    bit          mis;
    if (reset) begin
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (m_edges >= lat_lp && bus.to_mem_i.yumi) m_pend = 1'b0;
      else m_edges++;
    end else if (bus.to_mem_i.valid) begin
      idx  = int'(bus.addr_i[aw_lp+1:2]);
      sh   = 8 * int'(bus.addr_i[1:0]);
      wd   = bus.to_mem_i.write_data;
      word = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
      mis  = mis_en_lp && !bus.to_mem_i.byte_not_word && (bus.addr_i[1:0] != 2'b00);
      if (mis) begin
        m_data = 32'h0;
      end else if (bus.to_mem_i.wen) begin
        m_data = 32'h0;
        if (bus.to_mem_i.byte_not_word)
          word = (word & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
        else
          word = wd;
        ref_mem[idx] = word;
      end else begin
        m_data = bus.to_mem_i.byte_not_word ? ((word >> sh) & 32'hFF) : word;
      end
      m_err   = mis;
      m_pend  = 1'b1;
      m_edges = 1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    bit ey, ev;
    ey = !reset && !m_pend && bus.to_mem_i.valid;
    ev = !reset && m_pend && (m_edges >= lat_lp);
    check("mon_yumi",  32'(bus.from_mem_o.yumi),  32'(ey));
    check("mon_valid", 32'(bus.from_mem_o.valid), 32'(ev));
    if (reset) begin
      check("mon_rst_data", bus.from_mem_o.read_data, 32'h0);
      check("mon_rst_err",  32'(bus.error_o), 32'h0);
    end else if (ev) begin
      check("mon_data", bus.from_mem_o.read_data, m_data);
      check("mon_err",  32'(bus.error_o), 32'(m_err));
    end
  end

  task automatic issue(input bit wen, input bit bnw, input logic [31:0] addr, input logic [31:0] wd);
    bus.to_mem_i.valid         = 1'b1;
    bus.to_mem_i.wen           = wen;
    bus.to_mem_i.byte_not_word = bnw;
    bus.to_mem_i.write_data    = wd;
    bus.addr_i                 = addr;
  endtask

  task automatic wait_accept(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.from_mem_o.yumi && n < 32);
    check({nm, "/accept"}, 32'(bus.from_mem_o.yumi), 32'h1);
    @(posedge clk); #1;
    bus.to_mem_i.valid = 1'b0;
  endtask

  task automatic wait_resp(input string nm, input logic [31:0] exp_d, input bit exp_e);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.from_mem_o.valid && n < 32);
    check({nm, "/latency"}, 32'(n), 32'(lat_lp));
    check({nm, "/data"}, bus.from_mem_o.read_data, exp_d);
    check({nm, "/error"}, 32'(bus.error_o), 32'(exp_e));
  endtask

  task automatic ack();
    #1 bus.to_mem_i.yumi = 1'b1;
    @(posedge clk); #1;
    bus.to_mem_i.yumi = 1'b0;
  endtask

  task automatic xact(input string nm, input bit wen, input bit bnw, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_d, input bit exp_e);
    issue(wen, bnw, addr, wd);
    wait_accept(nm);
    wait_resp(nm, exp_d, exp_e);
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    bus.to_mem_i = '0;
    bus.addr_i   = 32'h0;
    @(negedge clk);
    check("rst_valid", 32'(bus.from_mem_o.valid), 32'h0);
    check("rst_yumi",  32'(bus.from_mem_o.yumi),  32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Word store / load with default latency.
    xact("st_beef", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("ld_beef", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte store into lane 3 leaves other lanes alone.
    xact("st_1122", 1'b1, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0);
    xact("st_b13",  1'b1, 1'b1, 32'h13, 32'hFFFFFFAA, 32'h0, 1'b0);

    // Response held for 5 cycles while a second request waits for yumi.
    issue(1'b0, 1'b0, 32'h10, 32'h0);
    wait_accept("ld_hold");
    wait_resp("ld_hold", 32'hAA223344, 1'b0);
    #1 issue(1'b0, 1'b1, 32'h13, 32'h0);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.from_mem_o.valid), 32'h1);
      check("hold_data",  bus.from_mem_o.read_data, 32'hAA223344);
      check("hold_yumi",  32'(bus.from_mem_o.yumi), 32'h0);
    end
    #1 bus.to_mem_i.yumi = 1'b1;
    @(posedge clk); #1;
    bus.to_mem_i.yumi = 1'b0;
    @(negedge clk);
    check("next_yumi", 32'(bus.from_mem_o.yumi), 32'h1);
    @(posedge clk); #1;
    bus.to_mem_i.valid = 1'b0;
    wait_resp("ldb_13", 32'h000000AA, 1'b0);
    ack();

    xact("ldb_10", 1'b0, 1'b1, 32'h10, 32'h0, 32'h00000044, 1'b0);
    xact("ldb_12", 1'b0, 1'b1, 32'h12, 32'h0, 32'h00000022, 1'b0);

    // Addresses wrap modulo the array depth.
    xact("st_wrap", 1'b1, 1'b0, 32'h1004, 32'h5, 32'h0, 1'b0);
    xact("ld_wrap", 1'b0, 1'b0, 32'h0004, 32'h0, 32'h5, 1'b0);

    // Misaligned word store.
    xact("st_20",  1'b1, 1'b0, 32'h20, 32'h0BADF00D, 32'h0, 1'b0);
    xact("st_22",  1'b1, 1'b0, 32'h22, 32'h12345678, 32'h0, mis_en_lp);
    xact("ld_20",  1'b0, 1'b0, 32'h20, 32'h0,
         mis_en_lp ? 32'h0BADF00D : 32'h12345678, 1'b0);

    // Reset while busy drops the response but keeps the committed store.
    xact("st_44", 1'b1, 1'b0, 32'h44, 32'hCAFEF00D, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 32'h48, 32'h600DD00D);
    wait_accept("st_48");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", 32'(bus.from_mem_o.valid), 32'h0);
    end
    @(posedge clk); #1;
    xact("ld_48", 1'b0, 1'b0, 32'h48, 32'h0, 32'h600DD00D, 1'b0);
    xact("ld_44", 1'b0, 1'b0, 32'h44, 32'h0, 32'hCAFEF00D, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
